lpr_box_locate: RTL and testbench
=================================

LPR_BOX_LOCATE -- requirements
Module: lpr_box_locate

Interface
REQ-001 Parameter ROW_TH, default 20: minimum mask pixels in a row for that row to qualify.
REQ-002 Parameter MIN_H, default 8: minimum qualifying-row span (bottom-top+1) for a valid box.
REQ-003 pixelclk  in  1  pixel clock; every register is clocked on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_bin  in  1  plate-colour mask for the current pixel; 1 means plate colour.
REQ-006 i_hsync, i_vsync, i_de  in  1 each  video timing; i_vsync is active-high; i_de is high on active pixels.
REQ-007 hcount, vcount  in  12 each  coordinates of the current pixel.
REQ-008 hcount_l, hcount_r, vcount_l, vcount_r  out  12 each  exclusive box bounds for the downstream overlay stage.
REQ-009 o_box_valid  out  1  high while the bounds describe a detected plate.
REQ-010 o_frame_done  out  1  one-cycle pulse when the bounds update.

Function
REQ-011 States: IDLE (waits for the first i_vsync rising edge), SCAN (accumulates statistics), LATCH (one cycle, updates outputs, then returns to SCAN).
REQ-012 Per row in SCAN: count pixels with i_de&&i_bin; the counter is 12 bits and saturates at 4095.
REQ-013 Per row: record the first and last hcount where i_de&&i_bin.
REQ-014 Row close is the i_de falling edge; at row close the row qualifies if count>=ROW_TH.
REQ-015 The row coordinate is the vcount registered on that row's last active pixel.
REQ-016 On a qualifying row: top is set only by the frame's first qualifying row; bottom is set to this row.
REQ-017 On a qualifying row: left becomes min(left, row first); right becomes max(right, row last).
REQ-018 At row close, the per-row statistics clear whether or not the row qualified.
REQ-019 Frame end is the i_vsync rising edge; the block enters LATCH on the next cycle.
REQ-020 Valid box: at least one qualifying row AND (bottom-top+1)>=MIN_H.
REQ-021 In LATCH with a valid box: hcount_l=left-1, vcount_l=top-1 (each saturating at 0); hcount_r=right+1, vcount_r=bottom+1 (each saturating at 4095); o_box_valid=1.
REQ-022 The ±1 expansion makes a downstream strict comparison (l < x < r) include the edge pixels.
REQ-023 In LATCH: o_frame_done=1 for exactly one cycle, and the frame accumulators clear.
REQ-024 Latency: outputs change exactly 2 cycles after the i_vsync rising edge and stay stable until the next LATCH.
REQ-025 If a row close and the i_vsync rising edge occur in the same cycle, that row is included in the frame before the latch.
REQ-026 Pixels arriving while in IDLE are ignored.

Reset
REQ-027 While reset_n is low, every output is 0 and the state is IDLE.
REQ-028 While reset_n is low, all accumulators clear.
REQ-029 Reset asserted mid-frame discards the partial frame; the first latch after release follows a complete frame.

Configuration
REQ-030 Macro LPR_BOX_HOLD_EN defined: an invalid frame leaves the previous bounds and o_box_valid unchanged; o_frame_done still pulses.
REQ-031 Macro LPR_BOX_HOLD_EN undefined: an invalid frame drives all four bounds and o_box_valid to 0.
REQ-032 With all bounds at 0, the downstream strict comparison matches no pixel.

Structure
REQ-033 Shared package lpr_pkg holds: the coordinate width constant (12), the ROW_TH/MIN_H defaults, and the state enum (IDLE/SCAN/LATCH).
REQ-034 Sub-module lpr_row_stat holds the per-row counter and the first/last column registers, and outputs the row-close strobe, count, first and last.

Verification
REQ-035 Rectangle of mask pixels at columns 100..299, rows 50..89 (count 200/row) -> after vsync: hcount_l=99, hcount_r=300, vcount_l=49, vcount_r=90, o_box_valid=1, o_frame_done pulse 2 cycles after the edge.
REQ-036 Rows with 19 mask pixels only -> no qualifying row -> with the macro, previous bounds are held; without it, all bounds=0 and o_box_valid=0.
REQ-037 Qualifying rows only at 10..16 (span 7) -> invalid box; at 10..17 (span 8) -> valid box with vcount_l=9, vcount_r=18.
REQ-038 Box at column 0 and row 4095 -> hcount_l=0 and vcount_r=4095 (saturated).
REQ-039 Final active row closes in the same cycle as the i_vsync rising edge -> that row sets bottom.
REQ-040 reset_n pulsed low mid-frame -> outputs 0 immediately; the next frame is ignored until the first vsync edge; the following full frame latches correctly.

Source files
------------

// File: rtl/lpr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lpr_pkg
// Purpose  : Shared constants, state type and saturating coordinate helpers
//            for the licence-plate box locator.
// Contents : c_coord_w (coordinate width), c_row_th_def / c_min_h_def
//            (default thresholds), state_t (IDLE/SCAN/LATCH), dec_sat/inc_sat.
// Revision : 1.0 - initial release
// ============================================================================
package lpr_pkg;

  localparam int c_coord_w    = 12;
  localparam int c_row_th_def = 20;
  localparam int c_min_h_def  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Coordinate minus one, clamped at 0.
  function automatic logic [c_coord_w-1:0] dec_sat(input logic [c_coord_w-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Coordinate plus one, clamped at the largest coordinate.
  function automatic logic [c_coord_w-1:0] inc_sat(input logic [c_coord_w-1:0] v);
    return (v == '1) ? '1 : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpr_row_stat.sv
`default_nettype none
// ============================================================================
// Module   : lpr_row_stat
// Purpose  : Per-row mask statistics. Counts plate-colour pixels on the
//            active line, remembers the first and last matching column and
//            the row coordinate, and flags the row close (i_de falling edge).
// Ports    : clk, rst_n          - clock, async active-low reset
//            i_en                - accumulate only while set
//            i_de, i_bin         - active-video and mask of current pixel
//            i_hcount, i_vcount  - current pixel coordinates
//            o_row_close         - strobe in the cycle i_de falls
//            o_count             - saturating mask-pixel count of the row
//            o_first, o_last     - first / last matching column
//            o_row_v             - vcount of the row's last active pixel
// Revision : 1.0 - initial release
// ============================================================================
module lpr_row_stat
  import lpr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_de,
  input  logic                 i_bin,
  input  logic [c_coord_w-1:0] i_hcount,
  input  logic [c_coord_w-1:0] i_vcount,
  output logic                 o_row_close,
  output logic [c_coord_w-1:0] o_count,
  output logic [c_coord_w-1:0] o_first,
  output logic [c_coord_w-1:0] o_last,
  output logic [c_coord_w-1:0] o_row_v
);

  logic                 r_de_d;
  logic [c_coord_w-1:0] r_cnt;
  logic [c_coord_w-1:0] r_first;
  logic [c_coord_w-1:0] r_last;
  logic [c_coord_w-1:0] r_row_v;
  logic                 w_hit;
  logic                 w_close;

  assign w_hit   = i_en & i_de & i_bin;
  // Stats still hold the whole row in the closing cycle; they clear on its edge.
  assign w_close = r_de_d & ~i_de;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_d  <= 1'b0;
      r_cnt   <= '0;
      r_first <= '0;
      r_last  <= '0;
      r_row_v <= '0;
    end else begin
      r_de_d <= i_de;
      if (w_close) begin
        r_cnt   <= '0;
        r_first <= '0;
        r_last  <= '0;
      end else if (w_hit) begin
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + 1'b1;
        end
        // A zero count means no match yet on this row (the count never wraps).
        if (r_cnt == '0) begin
          r_first <= i_hcount;
        end
        r_last <= i_hcount;
      end
      if (i_en && i_de) begin
        r_row_v <= i_vcount;
      end
    end
  end

  assign o_row_close = w_close;
  assign o_count     = r_cnt;
  assign o_first     = r_first;
  assign o_last      = r_last;
  assign o_row_v     = r_row_v;

endmodule
`default_nettype wire

// File: rtl/lpr_box_locate.sv
`default_nettype none
// ============================================================================
// Module   : lpr_box_locate
// Purpose  : Locates the bounding box of plate-coloured rows in a video frame
//            and publishes exclusive bounds once per frame.
// Ports    : pixelclk, reset_n         - clock, async active-low reset
//            i_bin                     - plate-colour mask
//            i_hsync, i_vsync, i_de    - video timing (vsync active-high)
//            hcount, vcount            - current pixel coordinates
//            hcount_l/_r, vcount_l/_r  - exclusive box bounds
//            o_box_valid               - bounds describe a detected plate
//            o_frame_done              - one-cycle pulse when bounds update
// Params   : ROW_TH - min mask pixels per qualifying row
//            MIN_H  - min span of qualifying rows for a valid box
// Macro    : LPR_BOX_HOLD_EN - when defined, an invalid frame keeps the
//            previous bounds and o_box_valid instead of zeroing them.
// Revision : 1.0 - initial release
// ============================================================================
module lpr_box_locate
  import lpr_pkg::*;
#(
  parameter int ROW_TH = c_row_th_def,
  parameter int MIN_H  = c_min_h_def
) (
  input  logic                 pixelclk,
  input  logic                 reset_n,
  input  logic                 i_bin,
  input  logic                 i_hsync,
  input  logic                 i_vsync,
  input  logic                 i_de,
  input  logic [c_coord_w-1:0] hcount,
  input  logic [c_coord_w-1:0] vcount,
  output logic [c_coord_w-1:0] hcount_l,
  output logic [c_coord_w-1:0] hcount_r,
  output logic [c_coord_w-1:0] vcount_l,
  output logic [c_coord_w-1:0] vcount_r,
  output logic                 o_box_valid,
  output logic                 o_frame_done
);

  localparam logic [c_coord_w-1:0] c_row_th   = c_coord_w'(ROW_TH);
  localparam logic [c_coord_w-1:0] c_min_h_m1 = c_coord_w'(MIN_H - 1);
`ifdef LPR_BOX_HOLD_EN
  localparam bit c_hold = 1'b1;
`else
  localparam bit c_hold = 1'b0;
`endif

  state_t               r_state;
  logic                 r_vs_d;
  logic                 r_have;
  logic [c_coord_w-1:0] r_top;
  logic [c_coord_w-1:0] r_bot;
  logic [c_coord_w-1:0] r_left;
  logic [c_coord_w-1:0] r_right;
  logic [c_coord_w-1:0] r_hl;
  logic [c_coord_w-1:0] r_hr;
  logic [c_coord_w-1:0] r_vl;
  logic [c_coord_w-1:0] r_vr;
  logic                 r_valid;
  logic                 r_done;

  logic                 w_vs_rise;
  logic                 w_row_close;
  logic [c_coord_w-1:0] w_row_cnt;
  logic [c_coord_w-1:0] w_row_first;
  logic [c_coord_w-1:0] w_row_last;
  logic [c_coord_w-1:0] w_row_v;
  logic                 w_row_qual;
  logic                 w_box_ok;
  logic                 w_load;
  logic                 w_unused;

  // Horizontal sync carries no information this block needs.
  assign w_unused  = i_hsync;
  assign w_vs_rise = i_vsync & ~r_vs_d;

  lpr_row_stat u_row_stat (
    .clk         (pixelclk),
    .rst_n       (reset_n),
    .i_en        (r_state == SCAN),
    .i_de        (i_de),
    .i_bin       (i_bin),
    .i_hcount    (hcount),
    .i_vcount    (vcount),
    .o_row_close (w_row_close),
    .o_count     (w_row_cnt),
    .o_first     (w_row_first),
    .o_last      (w_row_last),
    .o_row_v     (w_row_v)
  );

  // A row closing in the vsync-rise cycle is still taken here, since the
  // state only becomes LATCH on the following edge.
  assign w_row_qual = (r_state == SCAN) && w_row_close && (w_row_cnt >= c_row_th);
  assign w_box_ok   = r_have && (r_bot >= r_top) && ((r_bot - r_top) >= c_min_h_m1);
  assign w_load     = (r_state == LATCH) && (w_box_ok || !c_hold);

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_vs_d  <= 1'b0;
    end else begin
      r_vs_d <= i_vsync;
      case (r_state)
        IDLE:    if (w_vs_rise) r_state <= SCAN;
        SCAN:    if (w_vs_rise) r_state <= LATCH;
        LATCH:   r_state <= SCAN;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_have  <= 1'b0;
      r_top   <= '0;
      r_bot   <= '0;
      r_left  <= '0;
      r_right <= '0;
    end else if (r_state == LATCH) begin
      r_have  <= 1'b0;
      r_top   <= '0;
      r_bot   <= '0;
      r_left  <= '0;
      r_right <= '0;
    end else if (w_row_qual) begin
      r_have <= 1'b1;
      r_bot  <= w_row_v;
      if (!r_have) begin
        r_top   <= w_row_v;
        r_left  <= w_row_first;
        r_right <= w_row_last;
      end else begin
        if (w_row_first < r_left)  r_left  <= w_row_first;
        if (w_row_last  > r_right) r_right <= w_row_last;
      end
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_hl    <= '0;
      r_hr    <= '0;
      r_vl    <= '0;
      r_vr    <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == LATCH);
      if (w_load) begin
        r_hl    <= w_box_ok ? dec_sat(r_left)  : '0;
        r_vl    <= w_box_ok ? dec_sat(r_top)   : '0;
        r_hr    <= w_box_ok ? inc_sat(r_right) : '0;
        r_vr    <= w_box_ok ? inc_sat(r_bot)   : '0;
        r_valid <= w_box_ok;
      end
    end
  end

  assign hcount_l     = r_hl;
  assign hcount_r     = r_hr;
  assign vcount_l     = r_vl;
  assign vcount_r     = r_vr;
  assign o_box_valid  = r_valid;
  assign o_frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lpr_box_locate.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpr_box_locate
// Purpose  : Self-checking bench for lpr_box_locate. Frames of rows are
//            generated; a reference model derives the expected bounds from
//            the set of qualifying rows and pushes them into a scoreboard that
//            a monitor pops on every o_frame_done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpr_box_locate;

  localparam int ROW_TH = 20;
  localparam int MIN_H  = 8;

  logic        pixelclk = 1'b0;
  logic        reset_n  = 1'b0;
  logic        i_bin    = 1'b0;
  logic        i_hsync  = 1'b0;
  logic        i_vsync  = 1'b0;
  logic        i_de     = 1'b0;
  logic [11:0] hcount   = '0;
  logic [11:0] vcount   = '0;
  logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
  logic        o_box_valid, o_frame_done;

  lpr_box_locate #(.ROW_TH(ROW_TH), .MIN_H(MIN_H)) dut (
    .pixelclk     (pixelclk),
    .reset_n      (reset_n),
    .i_bin        (i_bin),
    .i_hsync      (i_hsync),
    .i_vsync      (i_vsync),
    .i_de         (i_de),
    .hcount       (hcount),
    .vcount       (vcount),
    .hcount_l     (hcount_l),
    .hcount_r     (hcount_r),
    .vcount_l     (vcount_l),
    .vcount_r     (vcount_r),
    .o_box_valid  (o_box_valid),
    .o_frame_done (o_frame_done)
  );

  always #5 pixelclk = ~pixelclk;

  int cyc = 0;
  always @(posedge pixelclk) cyc <= cyc + 1;

  typedef struct {
    int hl; int hr; int vl; int vr; int v; int at;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t prev;
  int   checks   = 0;
  int   failures = 0;
  int   stab_prints = 0;

  // Reference model state: qualifying rows of the current frame.
  bit   armed = 1'b0;
  int   q_rows[$];
  int   q_first[$];
  int   q_last[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic zero_exp(output exp_t e);
    e.hl = 0; e.hr = 0; e.vl = 0; e.vr = 0; e.v = 0; e.at = 0;
  endtask

  // Monitor: pops on each frame_done, otherwise outputs must stay put.
  always @(negedge pixelclk) begin
    if (reset_n) begin
      if (o_frame_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency_cycle", cyc, e.at);
          chk("hcount_l", int'(hcount_l), e.hl);
          chk("hcount_r", int'(hcount_r), e.hr);
          chk("vcount_l", int'(vcount_l), e.vl);
          chk("vcount_r", int'(vcount_r), e.vr);
          chk("box_valid", int'(o_box_valid), e.v);
          cur = e;
        end
      end else begin
        checks++;
        if (int'(hcount_l) != cur.hl || int'(hcount_r) != cur.hr ||
            int'(vcount_l) != cur.vl || int'(vcount_r) != cur.vr ||
            int'(o_box_valid) != cur.v) begin
          failures++;
          if (stab_prints < 10) begin
            stab_prints++;
            $display("FAIL outputs_stable actual=%0d/%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d/%0d (t=%0t)",
                     hcount_l, hcount_r, vcount_l, vcount_r, o_box_valid,
                     cur.hl, cur.hr, cur.vl, cur.vr, cur.v, $time);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  // Frame end seen by the model: the box is the span of qualifying rows.
  task automatic latch_model();
    exp_t e;
    if (!armed) begin
      armed = 1'b1;
    end else begin
      int top, bot, left, right;
      bit valid;
      valid = 1'b0;
      top = 0; bot = 0; left = 0; right = 0;
      if (q_rows.size() > 0) begin
        top = q_rows[0];
        bot = q_rows[q_rows.size()-1];
        left = 4095; right = 0;
        foreach (q_first[k]) if (q_first[k] < left) left = q_first[k];
        foreach (q_last[k])  if (q_last[k] > right) right = q_last[k];
        valid = (bot - top + 1) >= MIN_H;
      end
      if (valid) begin
        e.hl = (left > 0) ? left - 1 : 0;
        e.vl = (top > 0) ? top - 1 : 0;
        e.hr = (right < 4095) ? right + 1 : 4095;
        e.vr = (bot < 4095) ? bot + 1 : 4095;
        e.v  = 1;
      end else begin
`ifdef LPR_BOX_HOLD_EN
        e = prev;
`else
        zero_exp(e);
`endif
      end
      e.at = cyc + 2;
      prev = e;
      sb.push_back(e);
    end
    q_rows.delete();
    q_first.delete();
    q_last.delete();
  endtask

  // One active line: columns x0..x0+len-1, mask set within [b0,b1] with
  // probability dens%. Optionally the closing cycle coincides with vsync rise.
  task automatic drive_row(input int vc, input int x0, input int len, input int b0,
                           input int b1, input int dens, input bit close_with_vs);
    int cnt, f, l;
    cnt = 0; f = -1; l = -1;
    for (int i = 0; i < len; i++) begin
      int h;
      bit b;
      h = x0 + i;
      b = (h >= b0) && (h <= b1) && ($urandom_range(99) < dens);
      tick();
      i_de = 1'b1; hcount = h[11:0]; vcount = vc[11:0]; i_bin = b;
      if (b) begin
        cnt++;
        if (f < 0) f = h;
        l = h;
      end
    end
    if (armed && cnt >= ROW_TH) begin
      q_rows.push_back(vc);
      q_first.push_back(f);
      q_last.push_back(l);
    end
    tick();
    i_de = 1'b0; i_bin = 1'b0;
    if (close_with_vs) begin
      i_vsync = 1'b1;
      latch_model();
    end else begin
      i_hsync = 1'b1;
      tick();
      i_hsync = 1'b0;
      tick();
    end
  endtask

  task automatic end_frame(input bit already_high);
    if (!already_high) begin
      tick();
      i_vsync = 1'b1;
      latch_model();
    end
    repeat (3) tick();
    i_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_hcount_l"}, int'(hcount_l), 0);
    chk({tag, "_hcount_r"}, int'(hcount_r), 0);
    chk({tag, "_vcount_l"}, int'(vcount_l), 0);
    chk({tag, "_vcount_r"}, int'(vcount_r), 0);
    chk({tag, "_box_valid"}, int'(o_box_valid), 0);
    chk({tag, "_frame_done"}, int'(o_frame_done), 0);
  endtask

  task automatic model_reset();
    armed = 1'b0;
    q_rows.delete(); q_first.delete(); q_last.delete();
    sb.delete();
    zero_exp(cur);
    zero_exp(prev);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) tick();

    // Pixels before the first vsync are ignored; this vsync only arms.
    for (int r = 5; r < 20; r++) drive_row(r, 0, 30, 0, 29, 100, 1'b0);
    end_frame(1'b0);

    // Rectangle 100..299 x 50..89.
    for (int r = 50; r < 90; r++) drive_row(r, 98, 204, 100, 299, 100, 1'b0);
    end_frame(1'b0);

    // 19 mask pixels per row: nothing qualifies.
    for (int r = 0; r < 10; r++) drive_row(r, 10, 30, 12, 30, 100, 1'b0);
    end_frame(1'b0);

    // Span 7 (invalid) then span 8 (valid).
    for (int r = 10; r <= 16; r++) drive_row(r, 40, 25, 40, 64, 100, 1'b0);
    end_frame(1'b0);
    for (int r = 10; r <= 17; r++) drive_row(r, 40, 25, 40, 64, 100, 1'b0);
    end_frame(1'b0);

    // Box touching column 0 and row 4095.
    for (int r = 4088; r <= 4095; r++) drive_row(r, 0, 25, 0, 24, 100, 1'b0);
    end_frame(1'b0);

    // Last row closes in the vsync-rise cycle.
    for (int r = 200; r <= 209; r++) drive_row(r, 500, 30, 500, 529, 100, r == 209);
    end_frame(1'b1);

    // Random frames.
    for (int fr = 0; fr < 10; fr++) begin
      int vc, nrows;
      bit last_vs;
      vc      = $urandom_range(3000);
      nrows   = $urandom_range(14);
      last_vs = ($urandom_range(1) == 1) && (nrows > 0);
      for (int k = 0; k < nrows; k++) begin
        int x0, len;
        len = $urandom_range(45, 15);
        x0  = $urandom_range(4000);
        drive_row(vc, x0, len, x0 + $urandom_range(6), x0 + len - 1 - $urandom_range(6),
                  $urandom_range(100, 60), last_vs && (k == nrows - 1));
        vc = vc + $urandom_range(3, 1);
      end
      end_frame(last_vs);
    end

    // Reset mid-row: outputs drop at once and the partial frame is lost.
    for (int r = 700; r < 703; r++) drive_row(r, 10, 30, 10, 39, 100, 1'b0);
    tick();
    i_de = 1'b1; i_bin = 1'b1; hcount = 12'd10; vcount = 12'd703;
    tick();
    reset_n = 1'b0;
    i_de = 1'b0; i_bin = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("async_reset");
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    for (int r = 300; r < 312; r++) drive_row(r, 60, 30, 60, 89, 100, 1'b0);
    end_frame(1'b0);
    for (int r = 300; r < 312; r++) drive_row(r, 60, 30, 60, 89, 100, 1'b0);
    end_frame(1'b0);

    repeat (5) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout actual=%0d required=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
